// File: rtl/obi_dma_copy.sv
// Single-port OBI block copier: reads one word from src, writes it to dst, and repeats for len words.
// One transaction outstanding at a time; an illegal-access indication at grant aborts the job.
module obi_dma_copy #(
    parameter int unsigned LEN_W  = 16,
    parameter logic [3:0]  BE_ALL = 4'hF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_o,
    output logic             obi_req_o,
    input  logic             obi_gnt_i,
    output logic [31:0]      obi_addr_o,
    output logic             obi_we_o,
    output logic [3:0]       obi_be_o,
    output logic [31:0]      obi_wdata_o,
    input  logic             obi_rvalid_i,
    input  logic [31:0]      obi_rdata_i,
    input  logic             illegal_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_words;
    logic             r_err;

    logic [31:0]      w_src_nxt;
    logic [31:0]      w_dst_nxt;
    logic [31:0]      w_data_nxt;
    logic [LEN_W-1:0] w_rem_nxt;
    logic [LEN_W-1:0] w_words_nxt;
    logic             w_err_nxt;

    logic             r_busy;
    logic             r_done;
    logic             r_req;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_req_nxt;
    logic             w_we_nxt;
    logic [3:0]       w_be_nxt;
    logic [31:0]      w_addr_nxt;
    logic [31:0]      w_wdata_nxt;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (len_i == '0) ? S_FINISH : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (obi_gnt_i) begin
                    w_state_nxt = illegal_i ? S_FINISH : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (obi_rvalid_i) begin
                    w_state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (obi_gnt_i) begin
                    w_state_nxt = illegal_i ? S_FINISH : S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (obi_rvalid_i) begin
                    w_state_nxt = (r_rem == LEN_W'(1)) ? S_FINISH : S_RD_REQ;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Job datapath: pointers, remaining count, captured word, progress and abort flag
    always_comb begin
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_data_nxt  = r_data;
        w_rem_nxt   = r_rem;
        w_words_nxt = r_words;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_src_nxt   = src_addr_i & ADDR_MASK;
                    w_dst_nxt   = dst_addr_i & ADDR_MASK;
                    w_rem_nxt   = len_i;
                    w_words_nxt = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_RD_REQ, S_WR_REQ: begin
                if (obi_gnt_i && illegal_i) begin
                    w_err_nxt = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (obi_rvalid_i) begin
                    w_data_nxt = obi_rdata_i;
                end
            end
            S_WR_WAIT: begin
                if (obi_rvalid_i) begin
                    w_src_nxt   = r_src + ADDR_STEP;
                    w_dst_nxt   = r_dst + ADDR_STEP;
                    w_rem_nxt   = r_rem - LEN_W'(1);
                    w_words_nxt = r_words + LEN_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= '0;
            r_rem   <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_data  <= w_data_nxt;
            r_rem   <= w_rem_nxt;
            r_words <= w_words_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Output logic, decoded from the next state so every port comes straight from a flop
    always_comb begin
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_FINISH);
        w_req_nxt   = 1'b0;
        w_we_nxt    = r_we;
        w_be_nxt    = 4'h0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        case (w_state_nxt)
            S_RD_REQ: begin
                w_req_nxt  = 1'b1;
                w_we_nxt   = 1'b0;
                w_be_nxt   = BE_ALL;
                w_addr_nxt = w_src_nxt;
            end
            S_WR_REQ: begin
                w_req_nxt   = 1'b1;
                w_we_nxt    = 1'b1;
                w_be_nxt    = BE_ALL;
                w_addr_nxt  = w_dst_nxt;
                w_wdata_nxt = w_data_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_be    <= w_be_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign words_o     = r_words;
    assign obi_req_o   = r_req;
    assign obi_we_o    = r_we;
    assign obi_be_o    = r_be;
    assign obi_addr_o  = r_addr;
    assign obi_wdata_o = r_wdata;

endmodule

// File: tb/tb_obi_dma_copy.sv
// Bench for obi_dma_copy: behavioural OBI responder with a word memory, plus a job-level
// reference model that predicts the transaction list, final memory, counters and latency.
module tb_obi_dma_copy;

    localparam int unsigned LEN_W  = 16;
    localparam int          BUDGET = 3000;
    localparam logic [31:0] BE_ALL = 32'hF;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [31:0]      src_addr_i;
    logic [31:0]      dst_addr_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [LEN_W-1:0] words_o;
    logic             obi_req_o;
    logic             obi_gnt_i;
    logic [31:0]      obi_addr_o;
    logic             obi_we_o;
    logic [3:0]       obi_be_o;
    logic [31:0]      obi_wdata_o;
    logic             obi_rvalid_i;
    logic [31:0]      obi_rdata_i;
    logic             illegal_i;

    obi_dma_copy #(.LEN_W(LEN_W), .BE_ALL(4'hF)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_o      (words_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .illegal_i    (illegal_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic        ill;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        act_q[$];
    txn_t        exp_q[$];
    logic [31:0] dut_mem [logic [31:0]];
    logic [31:0] mdl_mem [logic [31:0]];

    int n_chk = 0;
    int n_err = 0;

    // Responder knobs, read by the responder process
    int cfg_rand        = 0;
    int cfg_lat         = 1;
    int cfg_stall_first = 0;
    int cfg_ill         = -1;
    int txn_idx         = 0;
    bit resp_on         = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] dut_rd(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        dut_mem[a] = v;
        mdl_mem[a] = v;
    endtask

    // OBI responder: optional grant stalls, configurable response latency, illegal injection
    initial begin : responder
        int          pend_cnt;
        logic [31:0] pend_data;
        int          stall_left;
        bit          stalling;
        logic [31:0] snap_addr;
        logic        snap_we;
        logic [31:0] snap_wdata;
        txn_t        t;
        pend_cnt   = 0;
        pend_data  = '0;
        stall_left = 0;
        stalling   = 1'b0;
        wait (resp_on);
        forever begin
            tick();
            obi_gnt_i    = 1'b0;
            illegal_i    = 1'b0;
            obi_rvalid_i = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    obi_rvalid_i = 1'b1;
                    obi_rdata_i  = pend_data;
                end
            end
            if (!obi_req_o) begin
                check_eq("be_idle", 32'(obi_be_o), 32'h0);
                if (stalling) begin
                    check_eq("req_dropped", 32'(obi_req_o), 32'h1);
                    stalling = 1'b0;
                end
            end else if (pend_cnt == 0) begin
                if (!stalling) begin
                    stalling   = 1'b1;
                    snap_addr  = obi_addr_o;
                    snap_we    = obi_we_o;
                    snap_wdata = obi_wdata_o;
                    if (txn_idx == 0) stall_left = cfg_stall_first;
                    else stall_left = (cfg_rand != 0) ? int'($urandom_range(0, 2)) : 0;
                end else begin
                    check_eq("hold_addr", obi_addr_o, snap_addr);
                    check_eq("hold_we", 32'(obi_we_o), 32'(snap_we));
                    if (snap_we) check_eq("hold_wdata", obi_wdata_o, snap_wdata);
                end
                check_eq("be_req", 32'(obi_be_o), BE_ALL);
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    obi_gnt_i = 1'b1;
                    stalling  = 1'b0;
                    illegal_i = (txn_idx == cfg_ill);
                    t.we    = obi_we_o;
                    t.ill   = illegal_i;
                    t.addr  = obi_addr_o;
                    t.wdata = obi_wdata_o;
                    act_q.push_back(t);
                    if (!obi_we_o) pend_data = dut_rd(obi_addr_o);
                    else begin
                        pend_data = $urandom;
                        if (!illegal_i) dut_mem[obi_addr_o] = obi_wdata_o;
                    end
                    pend_cnt = (cfg_rand != 0) ? int'($urandom_range(1, 3)) : cfg_lat;
                    txn_idx++;
                end
            end
        end
    end

    // One copy job: model the expected outcome, run the DUT, compare everything observable
    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int poke_at);
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] r;
        int          k;
        int          exp_words;
        bit          exp_err;
        int          exp_lat;
        int          n;
        int          lat;
        int          done_cnt;
        int          busy_cnt;
        txn_t        e;
        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        k = 0;
        exp_words = 0;
        exp_err   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            r = mdl_rd(s);
            e.we = 1'b0; e.ill = (k == cfg_ill); e.addr = s; e.wdata = '0;
            exp_q.push_back(e);
            if (k == cfg_ill) begin exp_err = 1'b1; break; end
            k++;
            e.we = 1'b1; e.ill = (k == cfg_ill); e.addr = d; e.wdata = r;
            exp_q.push_back(e);
            if (k == cfg_ill) begin exp_err = 1'b1; break; end
            k++;
            mdl_mem[d] = r;
            exp_words++;
            s += 32'd4;
            d += 32'd4;
        end
        // Zero-wait responder: 2 cycles per transaction, plus the FINISH cycle
        if (cfg_rand == 0 && cfg_stall_first == 0 && cfg_lat == 1)
            exp_lat = exp_err ? (2 * k + 2) : (4 * len + 1);
        else
            exp_lat = -1;

        act_q.delete();
        txn_idx    = 0;
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = LEN_W'(len);
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        src_addr_i = $urandom;
        dst_addr_i = $urandom;
        len_i      = LEN_W'($urandom);
        check_eq("err_clr_on_start", 32'(err_o), 32'h0);
        check_eq("words_clr_on_start", 32'(words_o), 32'h0);
        check_eq("busy_after_start", 32'(busy_o), 32'h1);

        n = 1; lat = -1; done_cnt = 0; busy_cnt = 0;
        while (busy_o && n <= BUDGET) begin
            busy_cnt++;
            if (done_o) begin done_cnt++; lat = n; end
            start_i = (n == poke_at);
            tick();
            start_i = 1'b0;
            n++;
        end
        check_eq("job_end", 32'(busy_o), 32'h0);
        check_eq("done_pulses", 32'(done_cnt), 32'h1);
        check_eq("done_in_last_busy", 32'(lat), 32'(busy_cnt));
        if (exp_lat >= 0) check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("words", 32'(words_o), 32'(exp_words));
        check_eq("err", 32'(err_o), 32'(exp_err));
        check_eq("req_idle", 32'(obi_req_o), 32'h0);
        check_eq("txn_count", 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check_eq("txn_we", 32'(act_q[i].we), 32'(exp_q[i].we));
            check_eq("txn_addr", act_q[i].addr, exp_q[i].addr);
            check_eq("txn_ill", 32'(act_q[i].ill), 32'(exp_q[i].ill));
            if (exp_q[i].we) check_eq("txn_wdata", act_q[i].wdata, exp_q[i].wdata);
        end
        foreach (exp_q[i]) begin
            if (exp_q[i].we && !exp_q[i].ill)
                check_eq("mem", dut_rd(exp_q[i].addr), mdl_rd(exp_q[i].addr));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int bad;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        src_addr_i   = '0;
        dst_addr_i   = '0;
        len_i        = '0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = '0;
        illegal_i    = 1'b0;
        repeat (3) tick();
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        check_eq("rst_done", 32'(done_o), 32'h0);
        check_eq("rst_err", 32'(err_o), 32'h0);
        check_eq("rst_words", 32'(words_o), 32'h0);
        check_eq("rst_req", 32'(obi_req_o), 32'h0);
        check_eq("rst_we", 32'(obi_we_o), 32'h0);
        check_eq("rst_be", 32'(obi_be_o), 32'h0);
        check_eq("rst_addr", obi_addr_o, 32'h0);
        check_eq("rst_wdata", obi_wdata_o, 32'h0);
        rst_i   = 1'b0;
        resp_on = 1'b1;
        tick();

        // Three-word copy, zero-wait responder
        preload(32'h8000_0000, 32'h1111_1111);
        preload(32'h8000_0004, 32'h2222_2222);
        preload(32'h8000_0008, 32'h3333_3333);
        run_job(32'h8000_0000, 32'h8000_0100, 3, 0);
        check_eq("copy3_w0", dut_rd(32'h8000_0100), 32'h1111_1111);
        check_eq("copy3_w2", dut_rd(32'h8000_0108), 32'h3333_3333);

        // Empty job
        run_job(32'h1234_5678, 32'h8765_4320, 0, 0);

        // Grant stall on the first read, unaligned inputs, DEADBEEF payload, start poked mid-job
        preload(32'h2000_0000, 32'hDEAD_BEEF);
        cfg_stall_first = 5;
        run_job(32'h2000_0003, 32'h3000_0002, 2, 3);
        check_eq("deadbeef_copied", dut_rd(32'h3000_0000), 32'hDEAD_BEEF);
        cfg_stall_first = 0;

        // Illegal at grant of the second write
        cfg_ill = 3;
        run_job(32'h8000_0000, 32'h9000_0000, 3, 0);
        cfg_ill = -1;
        repeat (3) tick();
        check_eq("err_sticky", 32'(err_o), 32'h1);
        check_eq("no_req_after_abort", 32'(obi_req_o), 32'h0);

        // Address wrap; start also clears the sticky error
        run_job(32'hFFFF_FFFC, 32'h1000_0000, 2, 0);

        // Reset while waiting for read data; late rvalid and a start on the reset edge are dropped
        cfg_lat = 6;
        act_q.delete();
        txn_idx    = 0;
        src_addr_i = 32'h4000_0000;
        dst_addr_i = 32'h5000_0000;
        len_i      = LEN_W'(2);
        start_i    = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (txn_idx == 0 && n < 50) begin tick(); n++; end
        check_eq("rst_test_grant", 32'(act_q.size()), 32'h1);
        tick();
        check_eq("rst_test_in_wait", 32'(busy_o & ~obi_req_o), 32'h1);
        rst_i   = 1'b1;
        start_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_o || done_o || obi_req_o) bad++;
            tick();
        end
        check_eq("rst_quiet_cycles", 32'(bad), 32'h0);
        check_eq("rst_no_write", 32'(act_q.size()), 32'h1);
        check_eq("rst_words_held", 32'(words_o), 32'h0);
        cfg_lat = 1;

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            int len;
            len = int'($urandom_range(0, 6));
            cfg_rand        = int'($urandom_range(0, 1));
            cfg_stall_first = (cfg_rand != 0) ? int'($urandom_range(0, 3)) : 0;
            cfg_ill         = (len > 0 && $urandom_range(0, 3) == 0) ?
                              int'($urandom_range(0, 2 * len - 1)) : -1;
            run_job($urandom, $urandom, len, (len > 1 && (j % 3) == 0) ? 2 : 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
